// File: rtl/game_status_timer_pkg.sv
// Shared definitions for the game status timer: timer state encoding and
// default parameter values.
package game_status_timer_pkg;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_RUN  = 2'd1,
      T_DONE = 2'd2
   } timer_state_e;

   localparam int unsigned DEF_TICK_DIV   = 50_000_000;
   localparam int unsigned DEF_HALT_TICKS = 3;
   localparam int unsigned DEF_LIVES_INIT = 3;
   localparam int unsigned DEF_LIFE_W     = 3;

endpackage

// File: rtl/game_status_timer_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 prescaler with a one-cycle TICK on the last count.
// CLR restarts the count so the next TICK lands exactly TICK_DIV clocks later.
import game_status_timer_pkg::*;

module game_status_timer_tick_prescaler #(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic CLR,
   output logic TICK
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/game_status_timer.sv
// Produces TC (hold-delay terminal count) and LIFE (last life) for the game-control
// FSM, plus the remaining-lives count for the display.
import game_status_timer_pkg::*;

module game_status_timer #(
   parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
   parameter int unsigned HALT_TICKS = DEF_HALT_TICKS,
   parameter int unsigned LIVES_INIT = DEF_LIVES_INIT,
   parameter int unsigned LIFE_W     = DEF_LIFE_W
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              HALT,
   input  logic              RESET,
   input  logic              LOADLIFE,
   input  logic              DEAD,
   output logic              TC,
   output logic              LIFE,
   output logic [LIFE_W-1:0] LIVES,
   output logic              TICK
);

   localparam int unsigned CNT_W = $clog2(HALT_TICKS + 1);

   timer_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tc_q, tc_d;
   logic [LIFE_W-1:0] lives_q, lives_d;
   logic              dead_q;
   logic              tick;
   logic              prescale_clr;
   logic              death_evt;

   game_status_timer_tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .CLK  (CLK),
      .RST_N(RST_N),
      .CLR  (prescale_clr),
      .TICK (tick)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tc_d         = 1'b0;
      prescale_clr = 1'b0;
      if (RESET) begin
         state_d = T_IDLE;
      end else begin
         case (state_q)
            T_IDLE: begin
               if (HALT) begin
                  cnt_d        = CNT_W'(HALT_TICKS);
                  prescale_clr = 1'b1;
                  state_d      = T_RUN;
               end
            end
            T_RUN: begin
               // Dropping HALT aborts the delay even on a tick cycle.
               if (!HALT) begin
                  state_d = T_IDLE;
               end else if (tick) begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     tc_d    = 1'b1;
                     state_d = T_DONE;
                  end
               end
            end
            T_DONE: begin
               if (!HALT) begin
                  state_d = T_IDLE;
               end
            end
            default: state_d = T_IDLE;
         endcase
      end
   end

   assign death_evt = DEAD & ~dead_q;

   always_comb begin
      lives_d = lives_q;
      if (LOADLIFE) begin
         lives_d = LIFE_W'(LIVES_INIT);
      end else if (death_evt && (lives_q != '0)) begin
         lives_d = lives_q - LIFE_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= T_IDLE;
         cnt_q   <= '0;
         tc_q    <= 1'b0;
         lives_q <= '0;
         dead_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         lives_q <= lives_d;
         dead_q  <= DEAD;
      end
   end

   assign TC    = tc_q;
   assign LIVES = lives_q;
   assign LIFE  = (lives_q <= LIFE_W'(1));
   assign TICK  = tick;

endmodule

// File: tb/tb_game_status_timer.sv
// Randomised plus directed bench for game_status_timer: a timestamp-based reference
// model fills a scoreboard, and a negedge monitor compares the DUT against it.
module tb_game_status_timer;

   localparam int TD    = 4;
   localparam int HT    = 3;
   localparam int LI    = 3;
   localparam int LW    = 3;
   localparam int DELAY = HT * TD;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          halt     = 1'b0;
   logic          reset    = 1'b0;
   logic          loadlife = 1'b0;
   logic          dead     = 1'b0;
   logic          tc, life, tick;
   logic [LW-1:0] lives;

   game_status_timer #(
      .TICK_DIV  (TD),
      .HALT_TICKS(HT),
      .LIVES_INIT(LI),
      .LIFE_W    (LW)
   ) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .HALT    (halt),
      .RESET   (reset),
      .LOADLIFE(loadlife),
      .DEAD    (dead),
      .TC      (tc),
      .LIFE    (life),
      .LIVES   (lives),
      .TICK    (tick)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at edge %0d", name, actual, expected, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {int at; int val;} lv_ev_t;
   int     tc_q[$];
   lv_ev_t lv_q[$];

   bit m_armed     = 1'b0;
   bit m_hold      = 1'b0;
   bit m_dead_prev = 1'b0;
   int m_due       = 0;
   int m_lives     = 0;
   int m_clr       = 0;   // edge after which the prescaler count is 0

   always @(posedge clk) begin
      int n;
      int old;
      n = cyc + 1;
      if (!rst_n) begin
         m_clr = n;
      end else begin
         if (reset) begin
            m_armed = 1'b0;
            m_hold  = 1'b0;
         end else if (m_armed) begin
            if (!halt) begin
               m_armed = 1'b0;
            end else if (n == m_due) begin
               tc_q.push_back(n);
               m_armed = 1'b0;
               m_hold  = 1'b1;
            end
         end else if (m_hold) begin
            if (!halt) m_hold = 1'b0;
         end else if (halt) begin
            m_armed = 1'b1;
            m_due   = n + DELAY;
            m_clr   = n;
         end

         old = m_lives;
         if (loadlife) m_lives = LI;
         else if (dead && !m_dead_prev && m_lives > 0) m_lives = m_lives - 1;
         m_dead_prev = dead;
         if (m_lives != old) lv_q.push_back('{n, m_lives});
      end
   end

   always @(negedge rst_n) begin
      m_armed     = 1'b0;
      m_hold      = 1'b0;
      m_dead_prev = 1'b0;
      m_lives     = 0;
      m_clr       = cyc;
      tc_q.delete();
      lv_q.delete();
      lv_q.push_back('{cyc, 0});
   end

   // ---------------- monitor ----------------
   int exp_lives = 0;

   always @(negedge clk) begin
      bit exp_tc;
      exp_tc = (tc_q.size() > 0) && (tc_q[0] == cyc);
      if (exp_tc) void'(tc_q.pop_front());
      check("tc", tc, exp_tc);
      while (lv_q.size() > 0 && lv_q[0].at <= cyc) begin
         exp_lives = lv_q[0].val;
         void'(lv_q.pop_front());
      end
      check("lives", lives, exp_lives);
      check("life", life, exp_lives <= 1);
      check("tick", tick, ((cyc - m_clr) % TD) == (TD - 1));
   end

   // ---------------- stimulus ----------------
   task automatic step(input int k);
      repeat (k) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_load();
      loadlife = 1'b1;
      step(1);
      loadlife = 1'b0;
      step(1);
   endtask

   initial begin
      step(3);
      rst_n = 1'b1;
      step(3);

      // Held HALT: one TC after the full delay, none afterwards.
      halt = 1'b1; step(25); halt = 1'b0; step(3);

      // Abort after 6 clocks, then a full-length re-arm.
      halt = 1'b1; step(6); halt = 1'b0; step(2);
      halt = 1'b1; step(18); halt = 1'b0; step(2);

      // Load then four deaths: 3 -> 2 -> 1 -> 0 -> 0.
      pulse_load();
      repeat (4) begin
         dead = 1'b1; step(2); dead = 1'b0; step(2);
      end

      // Long DEAD level counts once.
      pulse_load();
      dead = 1'b1; step(20); dead = 1'b0; step(2);

      // LOADLIFE wins over a simultaneous death at LIVES=1.
      pulse_load();
      repeat (2) begin
         dead = 1'b1; step(2); dead = 1'b0; step(2);
      end
      loadlife = 1'b1; dead = 1'b1; step(1);
      loadlife = 1'b0; step(2); dead = 1'b0; step(2);

      // Async reset mid-RUN (cnt=2).
      halt = 1'b1; step(6);
      rst_n = 1'b0;
      #1;
      check("rst_tc", tc, 1'b0);
      check("rst_lives", lives, 0);
      check("rst_life", life, 1'b1);
      halt = 1'b0; step(2);
      rst_n = 1'b1; step(16);

      // RESET pulse mid-RUN dominates HALT; re-arm afterwards.
      halt = 1'b1; step(7);
      reset = 1'b1; step(1);
      reset = 1'b0; halt = 1'b0; step(14);
      halt = 1'b1; step(16); halt = 1'b0; step(2);

      // Randomised traffic.
      repeat (3000) begin
         if ($urandom_range(15) == 0) halt = ~halt;
         reset    = ($urandom_range(63) == 0);
         loadlife = ($urandom_range(39) == 0);
         if ($urandom_range(5) == 0) dead = ~dead;
         if ($urandom_range(499) == 0) begin
            rst_n = 1'b0;
            #1;
            check("rnd_rst_tc", tc, 1'b0);
            check("rnd_rst_lives", lives, 0);
            step(2);
            rst_n = 1'b1;
         end
         step(1);
      end

      halt = 1'b0; reset = 1'b0; loadlife = 1'b0; dead = 1'b0;
      step(20);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
